// File: rtl/reg_bus_regfile_if.sv
// REG_BUS link between a bus master and a register-file responder.
interface reg_bus_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    ready;

    modport master (
        output addr, write, wdata, wstrb, valid,
        input  rdata, error, ready
    );

    modport slave (
        input  addr, write, wdata, wstrb, valid,
        output rdata, error, ready
    );
endinterface

// File: rtl/reg_bus_regfile.sv
// REG_BUS responder backed by NUM_REGS 32-bit software registers with programmable wait states.
// All register contents are exported on regs_o.
module reg_bus_regfile #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    reg_bus_regfile_if.slave               bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int unsigned IdxW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WordW = ADDR_WIDTH - 2;
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("reg_bus_regfile: DATA_WIDTH must be 32");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("reg_bus_regfile: WAIT_CYCLES must be 0..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                st_q, st_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  err_q, wr_q;
    logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
    logic [StrbW-1:0]      wstrb_q;
    logic [IdxW-1:0]       idx_q;

    logic [WordW-1:0]      word_addr;
    logic [IdxW-1:0]       idx;
    logic                  dec_err;

    // The upper address bits take part in the range check, so aliases are rejected.
    always_comb begin
        word_addr = bus.addr[ADDR_WIDTH-1:2];
        idx       = word_addr[IdxW-1:0];
        dec_err   = (bus.addr[1:0] != 2'b00) || (word_addr >= WordW'(NUM_REGS));
        if (!dec_err && bus.write && RO_MASK[idx]) begin
            dec_err = 1'b1;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (bus.valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        st_d = StResp;
                    end else begin
                        st_d  = StWait;
                        cnt_d = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    st_d = StResp;
                end
            end
            StResp:  st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= StIdle;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            if (accept) begin
                err_q   <= dec_err;
                wr_q    <= bus.write && !dec_err;
                rdata_q <= dec_err ? '0 : regs_q[idx];
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
                idx_q   <= idx;
            end
            // Write commits on the handshake edge.
            if (st_q == StResp && wr_q) begin
                for (int b = 0; b < StrbW; b++) begin
                    if (wstrb_q[b]) begin
                        regs_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.ready = (st_q == StResp);
    assign bus.error = err_q;
    assign bus.rdata = rdata_q;

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
        end
    end
endmodule

// File: tb/tb_reg_bus_regfile.sv
// Directed bench: a zero-wait instance (reg7 read-only) and a three-wait instance (reg0 read-only).
module tb_reg_bus_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bus_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    reg_bus_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();
    logic [255:0] regs0, regs3;

    reg_bus_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h80)
    ) u_dut0 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (if0.slave),
        .regs_o (regs0)
    );

    reg_bus_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h01)
    ) u_dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (if3.slave),
        .regs_o (regs3)
    );

    logic        sel = 1'b0;
    logic        write = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    assign if0.addr  = addr;
    assign if0.write = write;
    assign if0.wdata = wdata;
    assign if0.wstrb = wstrb;
    assign if0.valid = valid && !sel;
    assign if3.addr  = addr;
    assign if3.write = write;
    assign if3.wdata = wdata;
    assign if3.wstrb = wstrb;
    assign if3.valid = valid && sel;

    wire        ready_s = sel ? if3.ready : if0.ready;
    wire [31:0] rdata_s = sel ? if3.rdata : if0.rdata;
    wire        error_s = sel ? if3.error : if0.error;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    // One transaction starting in an IDLE cycle; returns one cycle after the ready pulse.
    task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int lat);
        sel = s; write = w; addr = a; wdata = d; wstrb = st; valid = 1'b1;
        lat = 0; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ready_s) begin
                lat = c; rd = rdata_s; er = error_s; valid = 1'b0;
                break;
            end
        end
        valid = 1'b0;
        if (lat == 0) begin
            n_checks++; n_fail++;
            $display("FAIL txn_timeout: no ready within 40 cycles at addr %0h", a);
        end
        @(posedge clk); #1;
    endtask

    vec_t        vecs[18];
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [255:0] exp0, exp3;
    int          rdy_at[4];
    int          nrdy, first;

    initial begin
        vecs[0]  = '{0, 1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         0, 1};
        vecs[1]  = '{0, 0, 32'h0000_0004, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 0, 1};
        vecs[2]  = '{0, 1, 32'h0000_0000, 32'h1122_3344, 4'hF, 0, 32'h0,         0, 1};
        vecs[3]  = '{0, 1, 32'h0000_0000, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         0, 1};
        vecs[4]  = '{0, 0, 32'h0000_0000, 32'h0,         4'h0, 1, 32'h11BB_33DD, 0, 1};
        vecs[5]  = '{0, 0, 32'h0000_0002, 32'h0,         4'h0, 1, 32'h0,         1, 1};
        vecs[6]  = '{0, 0, 32'h0000_0020, 32'h0,         4'h0, 1, 32'h0,         1, 1};
        vecs[7]  = '{0, 0, 32'h8000_0004, 32'h0,         4'h0, 1, 32'h0,         1, 1};
        vecs[8]  = '{0, 1, 32'h0000_001C, 32'h1234_5678, 4'hF, 1, 32'h0,         1, 1};
        vecs[9]  = '{0, 0, 32'h0000_001C, 32'h0,         4'h0, 1, 32'h0,         0, 1};
        vecs[10] = '{0, 1, 32'h0000_0008, 32'hCAFE_F00D, 4'h0, 0, 32'h0,         0, 1};
        vecs[11] = '{0, 0, 32'h0000_0008, 32'h0,         4'h0, 1, 32'h0,         0, 1};
        vecs[12] = '{0, 1, 32'h0000_0006, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,         1, 1};
        vecs[13] = '{0, 0, 32'h0000_0004, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 0, 1};
        vecs[14] = '{1, 1, 32'h0000_0000, 32'h5555_5555, 4'hF, 1, 32'h0,         1, 4};
        vecs[15] = '{1, 0, 32'h0000_0000, 32'h0,         4'h0, 1, 32'h0,         0, 4};
        vecs[16] = '{1, 1, 32'h0000_000C, 32'h0BAD_CAFE, 4'hF, 0, 32'h0,         0, 4};
        vecs[17] = '{1, 0, 32'h0000_000C, 32'h0,         4'h0, 1, 32'h0BAD_CAFE, 0, 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", 256'(if0.ready), 256'(0));
        check("rst_error0", 256'(if0.error), 256'(0));
        check("rst_rdata0", 256'(if0.rdata), 256'(0));
        check("rst_ready3", 256'(if3.ready), 256'(0));
        check("rst_regs0", regs0, '0);
        check("rst_regs3", regs3, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            txn(vecs[i].sel, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                rd, er, lat);
            check($sformatf("v%0d_err", i), 256'(er), 256'(vecs[i].exp_err));
            check($sformatf("v%0d_lat", i), 256'(lat), 256'(vecs[i].exp_lat));
            if (vecs[i].chk_rd) begin
                check($sformatf("v%0d_rdata", i), 256'(rd), 256'(vecs[i].exp_rd));
            end
        end

        exp0 = '0;
        exp0[31:0]  = 32'h11BB_33DD;
        exp0[63:32] = 32'hDEAD_BEEF;
        check("regs0_after_table", regs0, exp0);
        exp3 = '0;
        exp3[127:96] = 32'h0BAD_CAFE;
        check("regs3_after_table", regs3, exp3);

        // Wait-state instance: exactly one ready pulse, four cycles after valid.
        sel = 1'b1; write = 1'b0; addr = 32'h0000_000C; valid = 1'b1;
        nrdy = 0; first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (ready_s) begin
                nrdy++;
                if (first == 0) first = c;
                valid = 1'b0;
            end
        end
        valid = 1'b0;
        check("pulse_first", 256'(first), 256'(4));
        check("pulse_count", 256'(nrdy), 256'(1));

        // Back-to-back writes with valid held: one handshake every two cycles.
        sel = 1'b0; write = 1'b1; wstrb = 4'hF;
        addr = 32'h8; wdata = 32'hA000_0002; valid = 1'b1;
        nrdy = 0;
        for (int c = 1; c <= 20 && nrdy < 4; c++) begin
            @(posedge clk); #1;
            if (ready_s) begin
                rdy_at[nrdy] = c;
                nrdy++;
                addr  = 32'(4 * (nrdy + 2));
                wdata = 32'hA000_0002 + 32'(nrdy);
                if (nrdy == 4) valid = 1'b0;
            end
        end
        valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_count", 256'(nrdy), 256'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < nrdy) check($sformatf("b2b_t%0d", k), 256'(rdy_at[k]), 256'(1 + 2 * k));
        end
        exp0[95:64]   = 32'hA000_0002;
        exp0[127:96]  = 32'hA000_0003;
        exp0[159:128] = 32'hA000_0004;
        exp0[191:160] = 32'hA000_0005;
        check("b2b_regs0", regs0, exp0);

        // Reset during the wait phase of a write: nothing commits, no ready.
        sel = 1'b1; write = 1'b1; addr = 32'h8; wdata = 32'h7777_7777; wstrb = 4'hF;
        valid = 1'b1;
        nrdy = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ready_s) nrdy++;
        end
        rst = 1'b1;
        #1;
        if (ready_s) nrdy++;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready_s) nrdy++;
        end
        valid = 1'b0;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_s) nrdy++;
        end
        check("rst_mid_ready", 256'(nrdy), 256'(0));
        check("rst_mid_regs3", regs3, '0);
        check("rst_mid_regs0", regs0, '0);

        txn(1'b1, 1'b1, 32'h8, 32'h7777_7777, 4'hF, rd, er, lat);
        check("reissue_err", 256'(er), 256'(0));
        check("reissue_lat", 256'(lat), 256'(4));
        txn(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        check("reissue_rdata", 256'(rd), 256'(32'h7777_7777));
        exp3 = '0;
        exp3[95:64] = 32'h7777_7777;
        check("reissue_regs3", regs3, exp3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
